// File: rtl/dma_mem_responder.sv
// Avalon-MM slave backing single-beat DMA bridge reads/writes with one sector buffer,
// plus a priority controller port, an optional post-reset clear and a bridge write counter.
module dma_mem_responder #(
  parameter int ADDR_W         = 7,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [ADDR_W-1:0] ctl_addr,
  input  logic              ctl_rd,
  input  logic              ctl_wr,
  input  logic [31:0]       ctl_wdata,
  output logic [31:0]       ctl_rdata,
  output logic              ctl_rvalid,
  input  logic              xfer_clr,
  output logic [ADDR_W:0]   wr_count,
  output logic              sector_full
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state_q, state_d;
  logic   run;

  logic [ADDR_W-1:0] init_addr;
  logic [31:0]       mem [DEPTH];

  logic              bus_wr, bus_rd, ctl_we, ctl_re;
  logic              we_en;
  logic [ADDR_W-1:0] we_addr;
  logic [31:0]       we_data;
  logic [3:0]        we_be;

  logic [READ_LAT-1:0]       vld_pipe;
  logic [READ_LAT-1:0][31:0] dat_pipe;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
      init_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) init_addr <= init_addr + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      S_INIT: if (&init_addr) state_d = S_RUN;
      S_RUN:  run = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  // Controller traffic stalls the bridge for that cycle; reset also stalls it.
  assign avs_waitrequest = ~reset_n | ~run | ctl_rd | ctl_wr;
  assign bus_wr = avs_write & ~avs_waitrequest;
  assign bus_rd = avs_read & ~avs_write & ~avs_waitrequest;
  assign ctl_we = run & ctl_wr;
  assign ctl_re = run & ctl_rd & ~ctl_wr;

  always_comb begin
    we_en   = 1'b0;
    we_addr = '0;
    we_data = '0;
    we_be   = '0;
    if (state_q == S_INIT) begin
      we_en   = reset_n;
      we_addr = init_addr;
      we_be   = 4'hF;
    end else if (ctl_we) begin
      we_en   = 1'b1;
      we_addr = ctl_addr;
      we_data = ctl_wdata;
      we_be   = 4'hF;
    end else if (bus_wr) begin
      we_en   = 1'b1;
      we_addr = avs_address;
      we_data = avs_writedata;
      we_be   = avs_byteenable;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (we_en)
      for (int b = 0; b < 4; b++)
        if (we_be[b]) mem[we_addr][8*b +: 8] <= we_data[8*b +: 8];
  end

  // A port's read never shares a cycle with a write to the array, so a plain array
  // read already sees every earlier write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus_rd;
      if (bus_rd) dat_pipe[0] <= mem[avs_address];
      for (int s = 1; s < READ_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign avs_readdata      = dat_pipe[READ_LAT-1];
  assign avs_readdatavalid = vld_pipe[READ_LAT-1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ctl_rvalid <= 1'b0;
      ctl_rdata  <= '0;
    end else begin
      ctl_rvalid <= ctl_re;
      if (ctl_re) ctl_rdata <= mem[ctl_addr];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_count    <= '0;
      sector_full <= 1'b0;
    end else begin
      sector_full <= 1'b0;
      if (xfer_clr) begin
        wr_count <= '0;
      end else if (bus_wr && wr_count != FULL) begin
        wr_count    <= wr_count + 1'b1;
        sector_full <= (wr_count == FULL - 1'b1);
      end
    end
  end
endmodule
